// File: rtl/tlv_stream_walker.sv
// Walks a big-endian 64-bit word stream of back-to-back TLV records and emits {type, length, offset}.
// Optional macro TLV_WALK_CANON_EN: reject non-minimal compact-size encodings.
module tlv_stream_walker #(
    parameter int OFF_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      s_data,
    input  logic             s_valid,
    input  logic             s_last,
    input  logic [2:0]       s_nbytes,
    output logic             s_ready,
    output logic [31:0]      rec_type,
    output logic [63:0]      rec_len,
    output logic [OFF_W-1:0] rec_off,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic             msg_done,
    output logic             err
);

    typedef enum logic [2:0] {S_IDLE, S_TYPE, S_LEN, S_SKIP, S_ERR} state_t;

    localparam logic [64:0] OFF_MAX = (65'd1 << OFF_W) - 65'd1;

    state_t           r_state;
    logic [63:0]      r_buf;
    logic [3:0]       r_avail;
    logic             r_isLast;
    logic             r_alive;
    logic             r_ext;
    logic [3:0]       r_cnt;
    logic [55:0]      r_acc;
    logic [31:0]      r_type;
    logic [OFF_W-1:0] r_off;
    logic [63:0]      r_remain;
    logic [31:0]      r_recType;
    logic [63:0]      r_recLen;
    logic [OFF_W-1:0] r_recOff;
    logic             r_recValid;
    logic             r_msgDone;
    logic             r_err;
`ifdef TLV_WALK_CANON_EN
    logic [3:0]       r_width;
`endif

    logic [7:0]  w_byte;
    logic        w_hdr;
    logic        w_startExt;
    logic [3:0]  w_extWidth;
    logic        w_fieldDone;
    logic [63:0] w_fieldVal;
    logic        w_canonBad;
    logic        w_ovf;
    logic        w_stall;
    logic [3:0]  w_take;
    logic        w_msgEnd;
    logic        w_endClean;

    // The head of the buffer is always byte 0; consumed bytes are shifted out.
    always_comb begin
        w_byte      = r_buf[63:56];
        w_hdr       = (r_state == S_TYPE) || (r_state == S_LEN);
        w_startExt  = !r_ext && ((w_byte == 8'hFD) || (w_byte == 8'hFE) ||
                                 ((r_state == S_LEN) && (w_byte == 8'hFF)));
        case (w_byte)
            8'hFD:   w_extWidth = 4'd2;
            8'hFE:   w_extWidth = 4'd4;
            default: w_extWidth = 4'd8;
        endcase
        w_fieldDone = r_ext ? (r_cnt == 4'd1) : !w_startExt;
        w_fieldVal  = r_ext ? {r_acc, w_byte} : {56'd0, w_byte};
        w_canonBad  = 1'b0;
`ifdef TLV_WALK_CANON_EN
        if (r_ext && (r_cnt == 4'd1)) begin
            w_canonBad = ((r_width == 4'd2) && (w_fieldVal < 64'hFD)) ||
                         ((r_width == 4'd4) && (w_fieldVal <= 64'hFFFF)) ||
                         ((r_width == 4'd8) && (w_fieldVal <= 64'hFFFF_FFFF));
        end
`endif
        w_ovf   = (r_state == S_LEN) &&
                  ((65'(r_off) + 65'd1 + {1'b0, w_fieldVal}) > OFF_MAX);
        // Hold the last length byte while the record slot is still occupied.
        w_stall = (r_state == S_LEN) && w_fieldDone && r_recValid && !rec_ready;
        w_take  = 4'd0;
        if (r_avail != 4'd0) begin
            if (w_hdr && !w_stall) begin
                w_take = 4'd1;
            end else if (r_state == S_SKIP) begin
                w_take = (r_remain < {60'd0, r_avail}) ? r_remain[3:0] : r_avail;
            end
        end
        w_msgEnd   = r_isLast && (w_take != 4'd0) && (w_take == r_avail);
        w_endClean = ((r_state == S_SKIP) && (r_remain == {60'd0, w_take})) ||
                     ((r_state == S_LEN) && w_fieldDone && (w_fieldVal == 64'd0) && !w_canonBad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_buf      <= '0;
            r_avail    <= '0;
            r_isLast   <= 1'b0;
            r_alive    <= 1'b0;
            r_ext      <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_type     <= '0;
            r_off      <= '0;
            r_remain   <= '0;
            r_recType  <= '0;
            r_recLen   <= '0;
            r_recOff   <= '0;
            r_recValid <= 1'b0;
            r_msgDone  <= 1'b0;
            r_err      <= 1'b0;
`ifdef TLV_WALK_CANON_EN
            r_width    <= '0;
`endif
        end else begin
            r_alive   <= 1'b1;
            r_msgDone <= 1'b0;
            if (r_recValid && rec_ready) begin
                r_recValid <= 1'b0;
            end
            if (s_valid && s_ready) begin
                r_buf    <= s_data;
                r_avail  <= (s_last && (s_nbytes != 3'd0)) ? {1'b0, s_nbytes} : 4'd8;
                r_isLast <= s_last;
                if (r_state == S_IDLE) begin
                    r_state <= S_TYPE;
                end
            end else if (w_take != 4'd0) begin
                r_buf   <= r_buf << {w_take, 3'b000};
                r_avail <= r_avail - w_take;
                r_off   <= r_off + OFF_W'(w_take);
                if (r_state == S_SKIP) begin
                    r_remain <= r_remain - {60'd0, w_take};
                    if (w_endClean) begin
                        r_state <= S_TYPE;
                    end
                end else if (w_startExt) begin
                    r_ext <= 1'b1;
                    r_cnt <= w_extWidth;
                    r_acc <= '0;
`ifdef TLV_WALK_CANON_EN
                    r_width <= w_extWidth;
`endif
                end else if (!w_fieldDone) begin
                    r_acc <= w_fieldVal[55:0];
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    r_ext <= 1'b0;
                    if (w_canonBad || w_ovf) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else if (r_state == S_TYPE) begin
                        r_type  <= w_fieldVal[31:0];
                        r_state <= S_LEN;
                    end else begin
                        r_recType  <= r_type;
                        r_recLen   <= w_fieldVal;
                        r_recOff   <= r_off + OFF_W'(1);
                        r_recValid <= 1'b1;
                        r_remain   <= w_fieldVal;
                        r_state    <= (w_fieldVal == 64'd0) ? S_TYPE : S_SKIP;
                    end
                end
                // A message must end on a record boundary; anything else is a truncation.
                if (w_msgEnd) begin
                    if (w_endClean && !w_ovf) begin
                        r_msgDone <= 1'b1;
                        r_off     <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end
                end
            end
        end
    end

    assign s_ready   = r_alive && (r_avail == 4'd0) && (r_state != S_ERR);
    assign rec_type  = r_recType;
    assign rec_len   = r_recLen;
    assign rec_off   = r_recOff;
    assign rec_valid = r_recValid;
    assign msg_done  = r_msgDone;
    assign err       = r_err;

endmodule

// File: tb/tb_tlv_stream_walker.sv
// Self-checking bench for tlv_stream_walker: single-word vector table plus multi-word sequences,
// with expected records queued at stimulus time and compared as the DUT hands them off.
`timescale 1ns/1ps
module tb_tlv_stream_walker;

    localparam int OFF_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [63:0]      s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_last = 1'b0;
    logic [2:0]       s_nbytes = '0;
    logic             s_ready;
    logic [31:0]      rec_type;
    logic [63:0]      rec_len;
    logic [OFF_W-1:0] rec_off;
    logic             rec_valid;
    logic             rec_ready = 1'b1;
    logic             msg_done;
    logic             err;

    always #5 clk = ~clk;

    tlv_stream_walker #(.OFF_W(OFF_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_nbytes  (s_nbytes),
        .s_ready   (s_ready),
        .rec_type  (rec_type),
        .rec_len   (rec_len),
        .rec_off   (rec_off),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .msg_done  (msg_done),
        .err       (err)
    );

    typedef struct {
        logic [31:0] typ;
        logic [63:0] len;
        logic [15:0] off;
    } recExp_t;

    typedef struct {
        string       name;
        logic [63:0] data;
        logic [2:0]  nbytes;
        bit          hasRec;
        recExp_t     rec;
        bit          done;
        bit          isErr;
    } vec_t;

    localparam int NV = 13;

    recExp_t expQ[$];
    recExp_t monExp;
    vec_t    vecs[NV];
    int      nChecks = 0;
    int      nPass = 0;
    int      doneCount = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_nbytes = '0;
        s_data = '0;
        rec_ready = 1'b1;
        #1;
        checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
        checkOutput("rst_rec_valid", 64'(rec_valid), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_rec_fields", rec_len | 64'(rec_type) | 64'(rec_off) | 64'(msg_done), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expQ.delete();
        doneCount = 0;
        tick();
    endtask

    task automatic applyStimulus(input logic [63:0] data, input logic last, input logic [2:0] nbytes);
        int waitCnt = 0;
        while (!s_ready && waitCnt < 300) begin
            tick();
            waitCnt++;
        end
        if (!s_ready) begin
            nChecks++;
            $display("[TB] FAIL applyStimulus: s_ready got 0 after %0d cycles, required 1", waitCnt);
            return;
        end
        s_data = data;
        s_last = last;
        s_nbytes = nbytes;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    // Record / msg_done monitor, sampled mid-cycle; a record seen here is taken at the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (msg_done) doneCount++;
            if (rec_valid && rec_ready) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL record: unexpected type 0x%0h len 0x%0h off 0x%0h, required none",
                             rec_type, rec_len, rec_off);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("rec_type", 64'(rec_type), 64'(monExp.typ));
                    checkOutput("rec_len", rec_len, monExp.len);
                    checkOutput("rec_off", 64'(rec_off), 64'(monExp.off));
                end
            end
        end
    end

    task automatic checkEnd(input string name, input bit expDone, input bit expErr);
        checkOutput({name, "_err"}, 64'(err), 64'(expErr));
        checkOutput({name, "_done"}, 64'(doneCount), 64'(expDone));
        checkOutput({name, "_s_ready"}, 64'(s_ready), 64'(!expErr));
        checkOutput({name, "_pending"}, 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int waitCnt;
        vecs[0]  = '{"basic",    64'h0105AAAAAAAAAA77, 3'd7, 1'b1, '{32'h1,    64'd5,      16'd2}, 1'b1, 1'b0};
        vecs[1]  = '{"zeroLen",  64'h0500FFFFFFFFFFFF, 3'd2, 1'b1, '{32'h5,    64'd0,      16'd2}, 1'b1, 1'b0};
        vecs[2]  = '{"fdType",   64'hFD123403BBBBBB99, 3'd7, 1'b1, '{32'h1234, 64'd3,      16'd4}, 1'b1, 1'b0};
        vecs[3]  = '{"feType",   64'hFE00010000000055, 3'd6, 1'b1, '{32'h10000,64'd0,      16'd6}, 1'b1, 1'b0};
        vecs[4]  = '{"ffType",   64'hFF02CCCC11111111, 3'd4, 1'b1, '{32'hFF,   64'd2,      16'd2}, 1'b1, 1'b0};
        vecs[5]  = '{"ffLenCut", 64'h01FF000000000000, 3'd5, 1'b0, '{32'h0,    64'd0,      16'd0}, 1'b0, 1'b1};
        vecs[6]  = '{"skipCut",  64'h0103AA0000000000, 3'd3, 1'b1, '{32'h1,    64'd3,      16'd2}, 1'b0, 1'b1};
        vecs[7]  = '{"lenCut",   64'h01FD000000000000, 3'd3, 1'b0, '{32'h0,    64'd0,      16'd0}, 1'b0, 1'b1};
`ifdef TLV_WALK_CANON_EN
        vecs[8]  = '{"canonFd",  64'h01FD001000000000, 3'd4, 1'b0, '{32'h0,    64'd0,      16'd0}, 1'b0, 1'b1};
`else
        vecs[8]  = '{"canonFd",  64'h01FD001000000000, 3'd4, 1'b1, '{32'h1,    64'h10,     16'd4}, 1'b0, 1'b1};
`endif
        vecs[9]  = '{"offMax",   64'h01FDFFFB00000000, 3'd4, 1'b1, '{32'h1,    64'hFFFB,   16'd4}, 1'b0, 1'b1};
        vecs[10] = '{"offOvf",   64'h01FDFFFC00000000, 3'd4, 1'b0, '{32'h0,    64'd0,      16'd0}, 1'b0, 1'b1};
        vecs[11] = '{"lenOvf",   64'hFD1234FE00010000, 3'd0, 1'b0, '{32'h0,    64'd0,      16'd0}, 1'b0, 1'b1};
        vecs[12] = '{"typeCut",  64'hFD12000000000000, 3'd2, 1'b0, '{32'h0,    64'd0,      16'd0}, 1'b0, 1'b1};

        #2;
        for (int i = 0; i < NV; i++) begin
            resetDut();
            if (vecs[i].hasRec) expQ.push_back(vecs[i].rec);
            applyStimulus(vecs[i].data, 1'b1, vecs[i].nbytes);
            repeat (20) tick();
            checkEnd(vecs[i].name, vecs[i].done, vecs[i].isErr);
        end

        // Long value skipped word by word, followed by a zero-length record in the last word.
        resetDut();
        expQ.push_back('{32'h1234, 64'd256, 16'd6});
        expQ.push_back('{32'h1, 64'd0, 16'd264});
        applyStimulus(64'hFD1234FD0100BBBB, 1'b0, 3'd0);
        for (int w = 0; w < 31; w++) applyStimulus(64'hBBBBBBBBBBBBBBBB, 1'b0, 3'd0);
        applyStimulus(64'hBBBBBBBBBBBB0100, 1'b1, 3'd0);
        waitCnt = 0;
        while (doneCount == 0 && waitCnt < 100) begin
            tick();
            waitCnt++;
        end
        tick();
        checkEnd("longSkip", 1'b1, 1'b0);

        // Three zero-length records with the consumer stalled.
        resetDut();
        rec_ready = 1'b0;
        expQ.push_back('{32'h1, 64'd0, 16'd2});
        expQ.push_back('{32'h2, 64'd0, 16'd4});
        expQ.push_back('{32'h3, 64'd0, 16'd6});
        applyStimulus(64'h0100020003000000, 1'b1, 3'd6);
        repeat (10) tick();
        checkOutput("stall_valid", 64'(rec_valid), 64'd1);
        checkOutput("stall_type", 64'(rec_type), 64'd1);
        checkOutput("stall_s_ready", 64'(s_ready), 64'd0);
        checkOutput("stall_done", 64'(doneCount), 64'd0);
        rec_ready = 1'b1;
        repeat (15) tick();
        checkEnd("stall", 1'b1, 1'b0);

        // Reset asserted mid-skip with a record pending, then a fresh message.
        resetDut();
        rec_ready = 1'b0;
        applyStimulus(64'h01FD0100BBBBBBBB, 1'b0, 3'd0);
        repeat (8) tick();
        checkOutput("mid_valid", 64'(rec_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 64'(rec_valid), 64'd0);
        checkOutput("mid_rst_s_ready", 64'(s_ready), 64'd0);
        checkOutput("mid_rst_fields", rec_len | 64'(rec_type) | 64'(rec_off) | 64'(err), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        rec_ready = 1'b1;
        expQ.delete();
        doneCount = 0;
        expQ.push_back('{32'h1, 64'd5, 16'd2});
        applyStimulus(64'h0105AAAAAAAAAA77, 1'b1, 3'd7);
        repeat (20) tick();
        checkEnd("afterRst", 1'b1, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
